// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller (master) and unified memory (slave).
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_read;
    logic mem_write;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_read,
        output mem_write,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_read,
        input  mem_write,
        input  iord,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM for the RV32I multi-cycle datapath: FETCH/DECODE/EXEC/MEM/WB with memory wait and timeout.
// Define INSTRET_COUNTER_EN to build the retired-instruction counter; otherwise instret reads 0.
module multicycle_ctrl #(
    parameter int WAIT_TIMEOUT = 0,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_ctrl_if.master       mem_bus,
    input  logic [31:0]             inst,
    input  logic                    zero,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    pc_src,
    output logic                    reg_write,
    output logic                    mem_to_reg,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              alu_op,
    output logic [1:0]              imm_sel,
    output logic                    illegal,
    output logic                    bus_err,
    output logic                    retire,
    output logic [2:0]              state,
    output logic [CNT_W-1:0]        instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam int TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_wait_cnt;
    logic [6:0]      w_opcode;
    logic            w_is_lw;
    logic            w_waiting;
    logic            w_timeout;
    logic            w_mem_req;
    logic            w_mem_read;
    logic            w_mem_write;
    logic            w_iord;
    logic            w_unused_inst;

    assign w_opcode      = inst[6:0];
    assign w_is_lw       = (w_opcode == OP_LW);
    assign w_unused_inst = ^inst[31:7];

    // A wait cycle is a FETCH/MEM cycle without mem_ready; the Nth consecutive one aborts the request.
    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_bus.mem_ready;
    assign w_timeout = (WAIT_TIMEOUT > 0) && w_waiting && (r_wait_cnt == TW'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if ((WAIT_TIMEOUT > 0) && w_waiting && !w_timeout)
                r_wait_cnt <= r_wait_cnt + TW'(1);
            else
                r_wait_cnt <= '0;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_mem_req   = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_iord      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        imm_sel     = 2'b00;
        illegal     = 1'b0;
        bus_err     = 1'b0;
        retire      = 1'b0;
        // While rst is high every strobe stays low, even mid-handshake.
        if (!rst) begin
            case (r_state)
                S_IDLE: w_next = S_FETCH;
                S_FETCH: begin
                    w_mem_req  = 1'b1;
                    w_mem_read = 1'b1;
                    alu_src_b  = 2'b01;
                    if (mem_bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        w_next   = S_DECODE;
                    end else if (w_timeout) begin
                        w_mem_req  = 1'b0;
                        w_mem_read = 1'b0;
                        bus_err    = 1'b1;
                        w_next     = S_FETCH;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b10;
                    imm_sel   = 2'b10;
                    w_next    = S_EXEC;
                end
                S_EXEC: begin
                    case (w_opcode)
                        OP_R: begin
                            alu_src_a = 1'b1;
                            alu_op    = 2'b10;
                            w_next    = S_WB;
                        end
                        OP_I: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b10;
                            alu_op    = 2'b10;
                            w_next    = S_WB;
                        end
                        OP_LW: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b10;
                            w_next    = S_MEM;
                        end
                        OP_SW: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b10;
                            imm_sel   = 2'b01;
                            w_next    = S_MEM;
                        end
                        OP_BEQ: begin
                            alu_src_a = 1'b1;
                            alu_op    = 2'b01;
                            pc_write  = zero;
                            pc_src    = 1'b1;
                            retire    = 1'b1;
                            w_next    = S_FETCH;
                        end
                        default: begin
                            illegal = 1'b1;
                            w_next  = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    w_mem_req   = 1'b1;
                    w_iord      = 1'b1;
                    w_mem_read  = w_is_lw;
                    w_mem_write = !w_is_lw;
                    if (mem_bus.mem_ready) begin
                        retire = !w_is_lw;
                        w_next = w_is_lw ? S_WB : S_FETCH;
                    end else if (w_timeout) begin
                        w_mem_req   = 1'b0;
                        w_mem_read  = 1'b0;
                        w_mem_write = 1'b0;
                        bus_err     = 1'b1;
                        w_next      = S_FETCH;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = w_is_lw;
                    retire     = 1'b1;
                    w_next     = S_FETCH;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign mem_bus.mem_req   = w_mem_req;
    assign mem_bus.mem_read  = w_mem_read;
    assign mem_bus.mem_write = w_mem_write;
    assign mem_bus.iord      = w_iord;
    assign state             = r_state;

`ifdef INSTRET_COUNTER_EN
    logic [CNT_W-1:0] r_instret;

    always_ff @(posedge clk) begin
        if (rst)
            r_instret <= '0;
        else if (retire)
            r_instret <= r_instret + CNT_W'(1);
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction cycle scripts built from the instruction rules, checked every cycle.
module tb_multicycle_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 8;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_sel;
        logic       illegal;
        logic       bus_err;
        logic       retire;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        zero;
        logic [31:0] inst;
        exp_t        exp;
        bit          chk;
    } cyc_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   inst = '0;
    logic          zero = 1'b0;
    logic          ir_write, pc_write, pc_src, reg_write, mem_to_reg, alu_src_a;
    logic [1:0]    alu_src_b, alu_op, imm_sel;
    logic          illegal, bus_err, retire;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.WAIT_TIMEOUT(TMO), .CNT_W(CW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_bus    (bus),
        .inst       (inst),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_sel    (imm_sel),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .retire     (retire),
        .state      (state),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    cyc_t          q[$];
    cyc_t          tq[$];
    cyc_t          cur;
    bit            cur_valid = 1'b0;
    int            tests = 0;
    int            fails = 0;
    int            cyc_no = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [CW-1:0] want_cnt;
    exp_t          got_v, got_c, exp_c;

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic put(input logic rdy, input logic z, input logic [31:0] ins, input exp_t e);
        cyc_t x;
        x.rst   = 1'b0;
        x.ready = rdy;
        x.zero  = z;
        x.inst  = ins;
        x.exp   = e;
        x.chk   = 1'b1;
        tq.push_back(x);
    endtask

    // One memory request: 'waits' not-ready cycles, then ready; aborts with bus_err on the TMO-th wait.
    task automatic mem_phase(input int waits, input exp_t w, input exp_t d, input logic z,
                             input logic [31:0] ins, output bit ok);
        exp_t t;
        bit   done;
        int   k;
        ok   = 1'b0;
        done = 1'b0;
        k    = 0;
        while (!done) begin
            if (k == waits) begin
                put(1'b1, z, ins, d);
                ok   = 1'b1;
                done = 1'b1;
            end else if (k + 1 == TMO) begin
                t           = w;
                t.mem_req   = 1'b0;
                t.mem_read  = 1'b0;
                t.mem_write = 1'b0;
                t.bus_err   = 1'b1;
                put(1'b0, z, ins, t);
                done = 1'b1;
            end else begin
                put(1'b0, z, ins, w);
            end
            k++;
        end
    endtask

    // rst_at: -1 none, -2 random position, otherwise index of the cycle that gets rst.
    task automatic gen_instr(input logic [31:0] ins, input logic z, input int wf, input int wm,
                             input int rst_at, output int n);
        exp_t       w, d, e;
        bit         ok;
        int         f, ra;
        logic [6:0] op;
        cyc_t       x;
        tq.delete();
        op = ins[6:0];
        f  = wf;
        w  = mk(3'd1);
        w.mem_req   = 1'b1;
        w.mem_read  = 1'b1;
        w.alu_src_b = 2'b01;
        d           = w;
        d.ir_write  = 1'b1;
        d.pc_write  = 1'b1;
        ok = 1'b0;
        while (!ok) begin
            mem_phase(f, w, d, z, ins, ok);
            f = f - TMO;
        end
        e = mk(3'd2);
        e.alu_src_b = 2'b10;
        e.imm_sel   = 2'b10;
        put(rb(), z, ins, e);
        e = mk(3'd3);
        case (op)
            OP_R:   begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
            OP_I:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b10; end
            OP_LW:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            OP_SW:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.imm_sel = 2'b01; end
            OP_BEQ: begin
                e.alu_src_a = 1'b1;
                e.alu_op    = 2'b01;
                e.pc_write  = z;
                e.pc_src    = 1'b1;
                e.retire    = 1'b1;
            end
            default: e.illegal = 1'b1;
        endcase
        put(rb(), z, ins, e);
        ok = (op == OP_R) || (op == OP_I);
        if ((op == OP_LW) || (op == OP_SW)) begin
            w = mk(3'd4);
            w.mem_req   = 1'b1;
            w.iord      = 1'b1;
            w.mem_read  = (op == OP_LW);
            w.mem_write = (op == OP_SW);
            d           = w;
            d.retire    = (op == OP_SW);
            mem_phase(wm, w, d, z, ins, ok);
            ok = ok && (op == OP_LW);
        end
        if (ok) begin
            e = mk(3'd5);
            e.reg_write  = 1'b1;
            e.mem_to_reg = (op == OP_LW);
            e.retire     = 1'b1;
            put(rb(), z, ins, e);
        end
        ra = (rst_at == -2) ? int'($urandom_range(0, tq.size() - 1)) : rst_at;
        n  = 0;
        for (int i = 0; i < tq.size(); i++) begin
            x = tq[i];
            if (i == ra) begin
                x.rst   = 1'b1;
                x.ready = rb();
                x.exp   = mk(x.exp.st);
                q.push_back(x);
                x.rst = 1'b0;
                x.exp = mk(3'd0);
                q.push_back(x);
                n += 2;
                break;
            end
            q.push_back(x);
            n++;
        end
    endtask

    task automatic pin(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("[TB] FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic applyStimulus();
        cyc_t       x;
        int         n, sel, wf, wm, ra;
        logic [31:0] ins;
        logic [6:0] op;
        for (int i = 0; i < 4; i++) begin
            x.rst   = (i < 3);
            x.ready = rb();
            x.zero  = 1'b0;
            x.inst  = '0;
            x.exp   = mk(3'd0);
            x.chk   = (i != 0);
            q.push_back(x);
        end
        gen_instr(32'h002081B3, 1'b0, 0, 0, -1, n); pin("lat_r", n, 4);
        gen_instr(32'h00500093, 1'b1, 0, 0, -1, n); pin("lat_i", n, 4);
        gen_instr(32'h0040A183, 1'b0, 0, 3, -1, n); pin("lw_wait3", n, 8);
        pin("lw_mem_to_reg", int'(q[q.size() - 1].exp.mem_to_reg), 1);
        gen_instr(32'h0040A183, 1'b1, 0, 0, -1, n); pin("lat_lw", n, 5);
        gen_instr(32'h0020A223, 1'b0, 0, 0, -1, n); pin("lat_sw", n, 4);
        gen_instr(32'h00208463, 1'b1, 0, 0, -1, n); pin("lat_beq_z1", n, 3);
        pin("beq_pcw_z1", int'(q[q.size() - 1].exp.pc_write), 1);
        gen_instr(32'h00208463, 1'b0, 0, 0, -1, n); pin("lat_beq_z0", n, 3);
        pin("beq_pcw_z0", int'(q[q.size() - 1].exp.pc_write), 0);
        gen_instr(32'h0000007F, 1'b0, 0, 0, -1, n); pin("lat_illegal", n, 3);
        gen_instr(32'h002081B3, 1'b0, 4, 0, -1, n); pin("fetch_tmo", n, 8);
        gen_instr(32'h0040A183, 1'b0, 0, 4, -1, n); pin("mem_tmo", n, 7);
        gen_instr(32'h0020A223, 1'b0, 0, 5, 4, n);  pin("sw_rst_mid", n, 6);
        gen_instr(32'h002081B3, 1'b0, 0, 0, -1, n);
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 5));
            ins = $urandom;
            case (sel)
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LW;
                3: op = OP_SW;
                4: op = OP_BEQ;
                default: begin
                    op = 7'($urandom_range(0, 127));
                    while (op == OP_R || op == OP_I || op == OP_LW || op == OP_SW || op == OP_BEQ)
                        op = 7'($urandom_range(0, 127));
                end
            endcase
            ins[6:0] = op;
            wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
            wm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
            ra = ($urandom_range(0, 19) == 0) ? -2 : -1;
            gen_instr(ins, rb(), wf, wm, ra, n);
        end
    endtask

    // Single compare process: DUT outputs versus the scripted expectation, plus the retire count.
    always @(negedge clk) begin
        if (cur_valid) begin
            got_v = {state, bus.mem_req, bus.mem_read, bus.mem_write, bus.iord, ir_write, pc_write,
                     pc_src, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, imm_sel,
                     illegal, bus_err, retire};
`ifdef INSTRET_COUNTER_EN
            want_cnt = exp_cnt;
`else
            want_cnt = '0;
`endif
            if (cur.chk) checkOutput();
            if (cur.rst)
                exp_cnt = '0;
            else if (cur.exp.retire)
                exp_cnt = exp_cnt + 1'b1;
        end
    end

    task automatic checkOutput();
        got_c    = got_v;
        got_c.st = 3'd0;
        exp_c    = cur.exp;
        exp_c.st = 3'd0;
        tests++;
        if (got_v.st !== cur.exp.st) begin
            fails++;
            $display("[TB] FAIL state cyc=%0d got=%0d want=%0d", cyc_no, got_v.st, cur.exp.st);
        end
        tests++;
        if (got_c !== exp_c) begin
            fails++;
            $display("[TB] FAIL ctrl cyc=%0d st=%0d got=%h want=%h", cyc_no, cur.exp.st, got_c, exp_c);
        end
        tests++;
        if (instret !== want_cnt) begin
            fails++;
            $display("[TB] FAIL instret cyc=%0d got=%0d want=%0d", cyc_no, instret, want_cnt);
        end
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        applyStimulus();
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk);
            #1;
            rst           = q[i].rst;
            bus.mem_ready = q[i].ready;
            zero          = q[i].zero;
            inst          = q[i].inst;
            cur           = q[i];
            cyc_no        = i;
            cur_valid     = 1'b1;
        end
        @(posedge clk);
        #1;
        cur_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
